// File: rtl/unit_mux_pkg.sv
// Shared types and constants for the C/K/F unit-select mux arbiter.
package unit_mux_pkg;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [SEL_W-1:0] SEL_C    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_K    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_F    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

  localparam logic [1:0] IDX_C = 2'd0;
  localparam logic [1:0] IDX_K = 2'd1;
  localparam logic [1:0] IDX_F = 2'd2;

  // Anything that is not a clean one-hot parks the mux on the zero output.
  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] s;
    case (oh)
      3'b001:  s = SEL_C;
      3'b010:  s = SEL_K;
      3'b100:  s = SEL_F;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unit_mux_arbiter_if.sv
// Request/grant bundle between the source/display control logic and the arbiter.
interface unit_mux_arbiter_if;

  logic [unit_mux_pkg::N_REQ-1:0] req;
  logic [unit_mux_pkg::N_REQ-1:0] gnt;
  logic [unit_mux_pkg::SEL_W-1:0] sel;
  logic                           busy;
  logic                           hold_last;

  modport master (output req, input gnt, sel, busy, hold_last);
  modport slave  (input req, output gnt, sel, busy, hold_last);

endinterface

// File: rtl/unit_mux_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters, starting after 'last'.
module rr_pick3
  import unit_mux_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             pick_valid,
  output logic [1:0]       pick_idx
);

  logic [1:0] ord0, ord1, ord2;

  // Search order is last+1, last+2, last; 'last' therefore has lowest priority.
  always_comb begin
    ord0 = IDX_C;
    ord1 = IDX_K;
    ord2 = IDX_F;
    case (last)
      IDX_C: begin ord0 = IDX_K; ord1 = IDX_F; ord2 = IDX_C; end
      IDX_K: begin ord0 = IDX_F; ord1 = IDX_C; ord2 = IDX_K; end
      default: begin ord0 = IDX_C; ord1 = IDX_K; ord2 = IDX_F; end
    endcase

    pick_valid = |req;
    pick_idx   = IDX_C;
    if (req[ord0])      pick_idx = ord0;
    else if (req[ord1]) pick_idx = ord1;
    else if (req[ord2]) pick_idx = ord2;
  end

endmodule

// File: rtl/unit_mux_arbiter.sv
// Round-robin arbiter driving the C/K/F mux select, with a bounded grant length.
module unit_mux_arbiter
  import unit_mux_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  unit_mux_arbiter_if.slave  bus
);

  localparam int unsigned         CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              hold_last_q, hold_last_d;

  logic [1:0]        pick_last;
  logic              pick_valid;
  logic [1:0]        pick_idx;

  // While granted, the owner is the reference point so it drops to lowest priority.
  assign pick_last = (state_q == GRANT) ? owner_q : last_q;

  rr_pick3 u_pick (
    .req        (bus.req),
    .last       (pick_last),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDX_F;
      owner_q     <= IDX_C;
      gnt_q       <= '0;
      sel_q       <= SEL_NONE;
      busy_q      <= 1'b0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release or timeout hands off directly to the next winner, if any.
        if (!bus.req[owner_q] || (cnt_q == CNT_LAST)) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (pick_valid) begin
            state_d = GRANT;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    gnt_d       = (state_d == GRANT) ? (N_REQ'(1) << owner_d) : '0;
    sel_d       = onehot_to_sel(gnt_d);
    busy_d      = (state_d == GRANT);
    hold_last_d = (state_d == GRANT) && (cnt_d == CNT_LAST);
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.hold_last = hold_last_q;

endmodule

// File: tb/tb_unit_mux_arbiter.sv
// Bench for unit_mux_arbiter: directed scenarios plus random requests against a grant-history model.
module tb_unit_mux_arbiter;

  localparam int unsigned HOLD_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  unit_mux_arbiter_if bus();

  unit_mux_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {bus.gnt, bus.sel, bus.busy, bus.hold_last};

  // Model: who owns the mux, how many cycles it has had it, who was served last.
  int m_owner;
  int m_held;
  int m_last;

  function automatic int m_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 2;
  endtask

  task automatic m_clock(input logic [2:0] r);
    int p;
    if (m_owner < 0) begin
      p = m_pick(r, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_held  = 1;
      end
    end else if (!r[m_owner] || m_held == int'(HOLD_MAX)) begin
      m_last = m_owner;
      p = m_pick(r, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_held  = 1;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [6:0] m_exp();
    logic [2:0] g;
    if (m_owner < 0) return {3'b000, 2'b11, 1'b0, 1'b0};
    g = 3'b001 << m_owner;
    return {g, 2'(m_owner), 1'b1, (m_held == int'(HOLD_MAX))};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [2:0] r);
    bus.req = r;
    @(posedge clk);
    m_clock(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 3'b000;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    do_reset();
    total++;
    if (obs !== 7'b000_11_0_0) begin
      bad++; $display("FAIL reset_state got=%b want=%b", obs, 7'b000_11_0_0);
    end
    step(3'b010);
    step(3'b010);
    total++;
    if (obs !== 7'b010_01_1_0) begin
      bad++; $display("FAIL pre_async_grant got=%b want=%b", obs, 7'b010_01_1_0);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (obs !== 7'b000_11_0_0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs, 7'b000_11_0_0);
    end
    @(negedge clk);
    bus.req = 3'b111;
    rst_n   = 1'b1;
    step(3'b111);
    e = 7'b001_00_1_0;
    total++;
    if (obs !== e) begin
      bad++; $display("FAIL first_after_reset got=%b want=%b", obs, e);
    end
  endtask

  task automatic test_single();
    logic [6:0] e;
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      step((n <= 3) ? 3'b010 : 3'b000);
      e = (n <= 3) ? 7'b010_01_1_0 : 7'b000_11_0_0;
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL single cyc=%0d got=%b want=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_contention();
    logic [6:0] e;
    int slot;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step(3'b111);
      slot = ((n - 1) / 4) % 3;
      e = {3'(3'b001 << slot), 2'(slot), 1'b1, (n % 4 == 0)};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL contention cyc=%0d got=%b want=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_sole_timeout();
    logic [6:0] e;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      step(3'b100);
      e = {3'b100, 2'b10, 1'b1, (n % 4 == 0)};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL sole cyc=%0d got=%b want=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_handoff();
    logic [6:0] e;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      step((n <= 2) ? 3'b011 : 3'b010);
      e = (n <= 2) ? 7'b001_00_1_0 : {3'b010, 2'b01, 1'b1, (n == 6)};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL handoff cyc=%0d got=%b want=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    step(3'b010);
    step(3'b000);
    total++;
    if (obs !== 7'b000_11_0_0) begin
      bad++; $display("FAIL fair_idle got=%b want=%b", obs, 7'b000_11_0_0);
    end
    step(3'b101);
    total++;
    if (obs !== 7'b100_10_1_0) begin
      bad++; $display("FAIL fair_first got=%b want=%b", obs, 7'b100_10_1_0);
    end
    step(3'b001);
    total++;
    if (obs !== 7'b001_00_1_0) begin
      bad++; $display("FAIL fair_second got=%b want=%b", obs, 7'b001_00_1_0);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [6:0] e;
    do_reset();
    r = 3'b000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) r = 3'($urandom);
      step(r);
      e = m_exp();
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL random cyc=%0d req=%b got=%b want=%b", n, r, obs, e);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = 3'b000;
    m_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_sole_timeout();
    test_handoff();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unit_mux_arbiter.md
Name: unit_mux_arbiter

Overview:
- Round-robin arbiter that shares the 4-bit C/K/F unit-select mux among three requesters.
- Converts a one-hot grant into the mux 2-bit select code:
  - C = 00
  - K = 01
  - F = 10
  - none = 11, which drives the mux output to zero
- Bounds each grant to HOLD_MAX cycles so no source can starve the others.
- Sits between the source/display control logic and the mux's sel input.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one requester may hold the grant (legal 2..256)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  3  request lines; bit0=C, bit1=K, bit2=F; level-sensitive, held while access wanted
gnt  output  3  one-hot grant, same bit order as req; 000 when idle
sel  output  2  mux select code matching gnt (00/01/10), 11 when idle
busy  output  1  high while any grant active
hold_last  output  1  high during the final permitted cycle (cycle HOLD_MAX) of the current grant

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - gnt=000, sel=11, busy=0, hold_last=0.
  - State=IDLE, hold counter=0.
  - Last-served pointer=F (index 2), so the first priority after reset is C.
- All outputs are registered; there is no combinational path from req to any output.
- States:
  - IDLE: gnt=000, sel=11.
  - GRANT: exactly one gnt bit set; sel encodes it.
- Priority order: starts one position after the last-served index and wraps (2 -> 0). Checked order is last+1, last+2, last.
- IDLE -> GRANT:
  - At a clock edge where req != 000, the highest-priority requester is granted.
  - gnt/sel/busy are valid in the cycle after that edge (1-cycle latency).
  - Hold counter loads 0.
- In GRANT, evaluated at each edge:
  - Release: req[owner]=0 sampled.
  - Timeout: counter == HOLD_MAX-1.
  - On release or timeout:
    - Pointer updates to owner.
    - Re-arbitrate among the sampled req with the owner's bit included at lowest priority.
    - If any requester is selected, go directly to GRANT for it (no idle bubble) with counter=0; otherwise go to IDLE.
  - Otherwise: counter increments and the grant holds.
- Timeout with the owner as sole requester: the same requester is re-granted. gnt stays unchanged and the counter restarts at 0.
- hold_last: high exactly when state=GRANT and counter=HOLD_MAX-1, regardless of req.
- Counter width: $clog2(HOLD_MAX); saturation is impossible because of the timeout rule.
- Requests are assumed synchronous to clk. Synchronizers are out of scope.

Decomposition:
- Shared package unit_mux_pkg holds:
  - state enum {IDLE, GRANT}
  - select constants SEL_C=2'b00, SEL_K=2'b01, SEL_F=2'b10, SEL_NONE=2'b11
  - index constants IDX_C=0, IDX_K=1, IDX_F=2
  - function onehot_to_sel
- One combinational sub-module, rr_pick3:
  - Inputs: req[2:0], last[1:0].
  - Outputs: pick_valid, pick_idx[1:0].
  - Used for both the IDLE and GRANT re-arbitration paths.
- The FSM, counter and output registers live in the top.

Test Plan:
- Reset and async behaviour: assert rst_n=0 mid-grant (gnt=010), between clock edges → gnt=000, sel=11, busy=0, hold_last=0 before the next edge; release with req=111 → first grant is C (gnt=001, sel=00).
- Single request: req=010 sampled high at edge 0, low at edge 3 → gnt=010, sel=01, busy=1 in cycles 1-3; gnt=000, sel=11, busy=0 from cycle 4.
- Full contention, HOLD_MAX=4, req=111 held:
  - Grant sequence is C, K, F, C..., 4 cycles each, back-to-back with no sel=11 gap.
  - hold_last is high on cycles 4, 8, 12.
- Sole requester timeout: req=100 held for 10 cycles → gnt=100 and sel=10 continuous; hold_last pulses on cycles 4 and 8.
- Early handoff: C owner drops req[0] after 2 cycles while req[1]=1 → next cycle gnt=010, sel=01, counter restarted; hold_last is first high 4 cycles later.
- Fairness after release: last served=K, then req=101 from idle → F granted first (gnt=100), then C.
